// File: rtl/program_loader_pkg.sv
// program_loader_pkg
//   Shared definitions for the boot-time program loader: FSM state encoding,
//   stream header size and the default text-segment base address. Reused by
//   the UART-boot top level and the testbench.
package program_loader_pkg;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_e;

    localparam int          HEADER_BYTES         = 2;
    localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h0040_0000;

endpackage

// File: rtl/program_loader_if.sv
// program_loader_if
//   Groups the byte-stream handshake and the program-memory write bus.
//   slave  : the loader (consumes bytes, drives the memory write port)
//   master : the byte source / memory side (testbench or UART-boot top)
//   Byte_i/Byte_Valid_i/Byte_Ready_o : stream byte handshake
//   Mem_Write_o/Mem_Address_o/Mem_Data_o : one-cycle write strobe + payload
interface program_loader_if #(
    parameter int DATA_WIDTH = 32
);
    logic [7:0]            Byte_i;
    logic                  Byte_Valid_i;
    logic                  Byte_Ready_o;
    logic                  Mem_Write_o;
    logic [DATA_WIDTH-1:0] Mem_Address_o;
    logic [DATA_WIDTH-1:0] Mem_Data_o;

    modport slave (
        input  Byte_i, Byte_Valid_i,
        output Byte_Ready_o, Mem_Write_o, Mem_Address_o, Mem_Data_o
    );

    modport master (
        output Byte_i, Byte_Valid_i,
        input  Byte_Ready_o, Mem_Write_o, Mem_Address_o, Mem_Data_o
    );
endinterface

// File: rtl/program_loader_word_assembler.sv
// word_assembler
//   Little-endian 32-bit word assembly from a byte stream.
//   clk, reset   : clock, async active-high reset
//   clear_i      : drop any partial word and restart at byte 0
//   load_i       : accept byte_i into the next byte lane
//   byte_i       : incoming byte
//   word_o       : word including the byte being loaded this cycle
//   word_full_o  : high while the 4th byte of a word is being loaded
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear_i) begin
            cnt_d  = 2'd0;
            word_d = '0;
        end else if (load_i) begin
            cnt_d = cnt_q + 2'd1;
            word_d[{cnt_q, 3'b000} +: 8] = byte_i;
        end
    end

    // Exposing the next value lets the caller latch the complete word on the
    // same edge that accepts its last byte.
    assign word_o      = word_d;
    assign word_full_o = load_i && !clear_i && (cnt_q == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= 2'd0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end
endmodule

// File: rtl/program_loader.sv
// program_loader
//   Parses a length-prefixed, XOR-checksummed byte stream and writes the
//   payload as 32-bit words into program memory at consecutive addresses.
//   The core is held in reset until a load completes with a good checksum.
//   clk, reset   : clock, async active-high reset
//   Start_i      : restart pulse, honoured only in DONE/ERROR
//   Cpu_Reset_o  : core reset, low only in DONE
//   Done_o       : load finished, checksum good
//   Error_o      : oversize count or checksum mismatch
//   bus          : byte stream in, memory write port out
module program_loader
    import program_loader_pkg::*;
#(
    parameter int                    MEMORY_DEPTH = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Start_i,
    output logic               Cpu_Reset_o,
    output logic               Done_o,
    output logic               Error_o,
    program_loader_if.slave    bus
);
    localparam int          IDX_W   = $clog2(MEMORY_DEPTH) + 1;
    localparam logic [15:0] DEPTH16 = 16'(MEMORY_DEPTH);

    state_e                state_q, state_d;
    logic [15:0]           n_q, n_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [7:0]            csum_q, csum_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic        ready, accept, restart, word_full;
    logic [31:0] word;
    logic [15:0] n_full;
    logic [IDX_W-1:0] idx_next;

    assign ready   = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                     (state_q == DATA)   || (state_q == CHECK);
    assign accept  = ready && bus.Byte_Valid_i;
    // In DONE/ERROR ready is low, so a byte arriving with Start_i is never taken.
    assign restart = Start_i && ((state_q == DONE) || (state_q == ERROR));
    assign n_full  = {bus.Byte_i, n_q[7:0]};
    assign idx_next = idx_q + 1'b1;

    word_assembler u_asm (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (restart),
        .load_i      (accept && (state_q == DATA)),
        .byte_i      (bus.Byte_i),
        .word_o      (word),
        .word_full_o (word_full)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            LEN_LO: if (accept) begin
                n_d     = {8'h00, bus.Byte_i};
                csum_d  = bus.Byte_i;
                state_d = LEN_HI;
            end
            LEN_HI: if (accept) begin
                n_d    = n_full;
                csum_d = csum_q ^ bus.Byte_i;
                if (n_full > DEPTH16)     state_d = ERROR;
                else if (n_full == 16'd0) state_d = CHECK;
                else                      state_d = DATA;
            end
            DATA: if (accept) begin
                csum_d = csum_q ^ bus.Byte_i;
                if (word_full) begin
                    // Latch the write payload here so it is stable in WRITE
                    // and holds afterwards until the next strobe.
                    addr_d  = BASE_ADDRESS + DATA_WIDTH'({idx_q, 2'b00});
                    data_d  = word;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                idx_d   = idx_next;
                state_d = (16'(idx_next) == n_q) ? CHECK : DATA;
            end
            CHECK: if (accept) begin
                state_d = (bus.Byte_i == csum_q) ? DONE : ERROR;
            end
            DONE, ERROR: if (Start_i) begin
                n_d     = '0;
                idx_d   = '0;
                csum_d  = '0;
                state_d = LEN_LO;
            end
            default: state_d = LEN_LO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LEN_LO;
            n_q     <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            addr_q  <= BASE_ADDRESS;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign bus.Byte_Ready_o  = ready;
    assign bus.Mem_Write_o   = (state_q == WRITE);
    assign bus.Mem_Address_o = addr_q;
    assign bus.Mem_Data_o    = data_q;
    assign Done_o            = (state_q == DONE);
    assign Error_o           = (state_q == ERROR);
    assign Cpu_Reset_o       = (state_q != DONE);
endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
    import program_loader_pkg::*;

    typedef logic [7:0] bq_t[$];
    localparam logic [31:0] BASE = DEFAULT_BASE_ADDRESS;

    logic clk = 1'b0;
    logic reset;
    logic Start_i;
    logic Cpu_Reset_o, Done_o, Error_o;

    int errors = 0;
    int checks = 0;

    program_loader_if #(.DATA_WIDTH(32)) ifc ();

    program_loader #(
        .MEMORY_DEPTH (32),
        .DATA_WIDTH   (32),
        .BASE_ADDRESS (32'h0040_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Start_i     (Start_i),
        .Cpu_Reset_o (Cpu_Reset_o),
        .Done_o      (Done_o),
        .Error_o     (Error_o),
        .bus         (ifc.slave)
    );

    always #5 clk = ~clk;

    // Memory model: record every write strobe.
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    always @(negedge clk) begin
        if (ifc.Mem_Write_o) begin
            wa.push_back(ifc.Mem_Address_o);
            wd.push_back(ifc.Mem_Data_o);
        end
    end

    // Handshake monitor used while a stream is pushed with valid held high.
    logic mon_en = 1'b0;
    int   mon_rdy_lo = 0;
    int   mon_bad = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (!ifc.Byte_Ready_o) mon_rdy_lo++;
            if (ifc.Byte_Ready_o == ifc.Mem_Write_o) mon_bad++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        ifc.Byte_i       = b;
        ifc.Byte_Valid_i = 1'b1;
        t = 0;
        while (!ifc.Byte_Ready_o && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) begin
            errors++; checks++;
            $display("FAIL send_byte timeout: ready stayed 0, required 1 (byte %h)", b);
        end
        @(posedge clk); #1;
        ifc.Byte_Valid_i = 1'b0;
    endtask

    task automatic send_all(input bq_t s);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic pulse_start();
        Start_i = 1'b1;
        @(posedge clk); #1;
        Start_i = 1'b0;
    endtask

    task automatic check_status(input string nm, input logic d, input logic e, input logic c);
        checks++;
        if ({Done_o, Error_o, Cpu_Reset_o} !== {d, e, c}) begin
            errors++;
            $display("FAIL %s status: done/err/cpurst=%b%b%b required %b%b%b",
                     nm, Done_o, Error_o, Cpu_Reset_o, d, e, c);
        end
    endtask

    task automatic check_write(input string nm, input int i, input logic [31:0] a, input logic [31:0] d);
        checks++;
        if (i >= wa.size()) begin
            errors++;
            $display("FAIL %s write %0d missing: got %0d writes", nm, i, wa.size());
        end else if (wa[i] !== a || wd[i] !== d) begin
            errors++;
            $display("FAIL %s write %0d: addr=%h data=%h required addr=%h data=%h",
                     nm, i, wa[i], wd[i], a, d);
        end
    endtask

    task automatic check_nw(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s write count: %0d required %0d", nm, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        checks++;
        if (ifc.Byte_Ready_o !== 1'b1 || ifc.Mem_Write_o !== 1'b0 ||
            ifc.Mem_Address_o !== BASE || ifc.Mem_Data_o !== 32'h0) begin
            errors++;
            $display("FAIL %s bus: rdy=%b wr=%b addr=%h data=%h required 1 0 %h 0",
                     nm, ifc.Byte_Ready_o, ifc.Mem_Write_o, ifc.Mem_Address_o,
                     ifc.Mem_Data_o, BASE);
        end
        check_status(nm, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1; Start_i = 1'b0;
        ifc.Byte_i = 8'h55; ifc.Byte_Valid_i = 1'b1;   // must be ignored
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        ifc.Byte_Valid_i = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("after_reset");
    endtask

    task automatic test_single();
        bq_t s;
        int b = wa.size();
        // 01^00^13^05^A0^00 = B7
        s = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB7};
        send_all(s);
        check_nw("single", wa.size() - b, 1);
        check_write("single", b, BASE, 32'h00A0_0513);
        check_status("single", 1'b1, 1'b0, 1'b0);
        checks++;
        if (ifc.Byte_Ready_o !== 1'b0) begin
            errors++;
            $display("FAIL single ready in DONE: %b required 0", ifc.Byte_Ready_o);
        end
    endtask

    task automatic test_back_to_back();
        bq_t s;
        int b = wa.size();
        int lo0 = mon_rdy_lo;
        int bad0 = mon_bad;
        s = '{8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
              8'h01, 8'h00, 8'h00, 8'h00, 8'h64};
        pulse_start();
        mon_en = 1'b1;
        send_all(s);
        mon_en = 1'b0;
        check_nw("b2b", wa.size() - b, 3);
        check_write("b2b", b,     BASE,          32'h1122_3344);
        check_write("b2b", b + 1, BASE + 32'h4,  32'hDEAD_BEEF);
        check_write("b2b", b + 2, BASE + 32'h8,  32'h0000_0001);
        checks++;
        if (mon_rdy_lo - lo0 !== 3 || mon_bad - bad0 !== 0) begin
            errors++;
            $display("FAIL b2b ready pattern: low_cycles=%0d bad=%0d required 3 0",
                     mon_rdy_lo - lo0, mon_bad - bad0);
        end
        check_status("b2b", 1'b1, 1'b0, 1'b0);
        // Outputs hold their last written values between strobes.
        checks++;
        if (ifc.Mem_Address_o !== BASE + 32'h8 || ifc.Mem_Data_o !== 32'h1) begin
            errors++;
            $display("FAIL b2b hold: addr=%h data=%h required %h 00000001",
                     ifc.Mem_Address_o, ifc.Mem_Data_o, BASE + 32'h8);
        end
    endtask

    task automatic test_oversize();
        bq_t s;
        int b = wa.size();
        s = '{8'h21, 8'h00};
        pulse_start();
        send_all(s);
        check_status("oversize", 1'b0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_nw("oversize", wa.size() - b, 0);
    endtask

    task automatic test_zero_ok();
        bq_t s;
        int b = wa.size();
        s = '{8'h00, 8'h00, 8'h00};
        pulse_start();
        send_all(s);
        check_status("zero_ok", 1'b1, 1'b0, 1'b0);
        check_nw("zero_ok", wa.size() - b, 0);
    endtask

    task automatic test_start_collision();
        bq_t s;
        int b = wa.size();
        Start_i = 1'b1; ifc.Byte_i = 8'hFF; ifc.Byte_Valid_i = 1'b1;
        @(posedge clk); #1;
        Start_i = 1'b0; ifc.Byte_Valid_i = 1'b0;
        checks++;
        if (ifc.Byte_Ready_o !== 1'b1 || Done_o !== 1'b0) begin
            errors++;
            $display("FAIL collision restart: rdy=%b done=%b required 1 0",
                     ifc.Byte_Ready_o, Done_o);
        end
        // 01^00^78^56^34^12 = 09
        s = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
        send_all(s);
        check_nw("collision", wa.size() - b, 1);
        check_write("collision", b, BASE, 32'h1234_5678);
        check_status("collision", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_zero_bad();
        bq_t s;
        s = '{8'h00, 8'h00, 8'h01};
        pulse_start();
        send_all(s);
        check_status("zero_bad", 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_full_depth();
        bq_t s;
        int b = wa.size();
        s = '{8'h20, 8'h00};
        for (int i = 0; i < 32; i++)
            for (int k = 0; k < 4; k++) s.push_back(8'(i));
        s.push_back(8'h20);   // each word's identical bytes cancel out
        pulse_start();
        send_all(s);
        check_nw("full", wa.size() - b, 32);
        check_write("full", b,      BASE,          32'h0000_0000);
        check_write("full", b + 31, BASE + 32'h7C, 32'h1F1F_1F1F);
        check_status("full", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midload();
        bq_t s;
        int b;
        s = '{8'h02, 8'h00, 8'hAA, 8'hBB};
        pulse_start();
        send_all(s);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midload_rst");
        reset = 1'b0;
        @(posedge clk); #1;
        b = wa.size();
        s = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
        send_all(s);
        check_nw("midload", wa.size() - b, 2);
        check_write("midload", b,     BASE,         32'h0403_0201);
        check_write("midload", b + 1, BASE + 32'h4, 32'h0807_0605);
        check_status("midload", 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; Start_i = 1'b0;
        ifc.Byte_i = 8'h00; ifc.Byte_Valid_i = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_oversize();
        test_zero_ok();
        test_start_collision();
        pulse_start();
        test_zero_bad();
        test_full_depth();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
